// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one uart_tx between N_REQ requesters.
// Each grant loads one byte, holds send until the frame completes, then idles for a gap.
module uart_tx_sched #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                       clk_tx,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [8*N_REQ-1:0]         req_data,
   output logic [N_REQ-1:0]           ack,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   input  logic                       tx_busy,
   output logic                       load_data,
   output logic                       send_data,
   output logic [7:0]                 datain_tx,
   output logic                       sched_busy,
   output logic                       timeout_err,
   input  logic                       err_clr
);

   localparam int unsigned IdW     = $clog2(N_REQ);
   localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
   localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StHalt} state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               load_q, load_d;
   logic               send_q, send_d;
   logic [7:0]         data_q, data_d;
   logic [IdW-1:0]     grant_q, grant_d;
   logic [IdW-1:0]     last_q, last_d;
   logic               sbusy_q, sbusy_d;
   logic               terr_q, terr_d;
   logic               seen_q, seen_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   logic               win_valid;
   logic [IdW-1:0]     win_idx;
   logic [7:0]         win_byte;
   logic [IdW-1:0]     cidx;
   int                 cand;

   // Round-robin search: first set request after last_q, wrapping around.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      win_byte  = '0;
      cand      = 0;
      cidx      = '0;
      for (int o = 1; o <= int'(N_REQ); o++) begin
         cand = (int'(last_q) + o) % int'(N_REQ);
         cidx = cand[IdW-1:0];
         if (!win_valid && req[cidx]) begin
            win_valid = 1'b1;
            win_idx   = cidx;
            win_byte  = req_data[{cidx, 3'b000} +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      load_d  = 1'b0;
      send_d  = send_q;
      data_d  = data_q;
      grant_d = grant_q;
      last_d  = last_q;
      terr_d  = terr_q;
      seen_d  = seen_q;
      cnt_d   = cnt_q;

      if (err_clr) terr_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!tx_busy && win_valid) begin
               ack_d[win_idx] = 1'b1;
               load_d         = 1'b1;
               data_d         = win_byte;
               grant_d        = win_idx;
               last_d         = win_idx;
               state_d        = StLoad;
            end
         end
         StLoad: begin
            send_d  = 1'b1;
            seen_d  = 1'b0;
            cnt_d   = '0;
            state_d = StSend;
         end
         StSend: begin
            if (tx_busy) seen_d = 1'b1;
            if (!tx_busy && seen_q) begin
               send_d  = 1'b0;
               cnt_d   = '0;
               state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               // Frame never completed: park until software clears the error.
               send_d  = 1'b0;
               terr_d  = 1'b1;
               state_d = StHalt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == CntW'(GapLast)) state_d = StIdle;
            else                         cnt_d   = cnt_q + 1'b1;
         end
         StHalt: begin
            if (err_clr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      sbusy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_tx) begin
      if (rst) begin
         state_q <= StIdle;
         ack_q   <= '0;
         load_q  <= 1'b0;
         send_q  <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         last_q  <= IdW'(N_REQ - 1);
         sbusy_q <= 1'b0;
         terr_q  <= 1'b0;
         seen_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         load_q  <= load_d;
         send_q  <= send_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         sbusy_q <= sbusy_d;
         terr_q  <= terr_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack         = ack_q;
   assign load_data   = load_q;
   assign send_data   = send_q;
   assign datain_tx   = data_q;
   assign grant_id    = grant_q;
   assign sched_busy  = sbusy_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx model, round-robin reference and
// scenario tasks; a second instance covers the zero-gap configuration.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst, err_clr;
   logic [3:0]  req, ack;
   logic [31:0] req_data;
   logic [1:0]  grant_id;
   logic        tx_busy, load_data, send_data, sched_busy, timeout_err;
   logic [7:0]  datain_tx;

   logic [3:0]  req0, ack0;
   logic [31:0] req_data0;
   logic [1:0]  gid0;
   logic        busy0, load0, send0, sb0, terr0;
   logic [7:0]  data0;

   int vectors = 0;
   int miscompares = 0;
   int m_last;
   int nload0 = 0;

   always #5 clk = ~clk;

   uart_tx_sched dut (
      .clk_tx(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
      .grant_id(grant_id), .tx_busy(tx_busy), .load_data(load_data), .send_data(send_data),
      .datain_tx(datain_tx), .sched_busy(sched_busy), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   uart_tx_sched #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT(16)) dut0 (
      .clk_tx(clk), .rst(rst), .req(req0), .req_data(req_data0), .ack(ack0),
      .grant_id(gid0), .tx_busy(busy0), .load_data(load0), .send_data(send0),
      .datain_tx(data0), .sched_busy(sb0), .timeout_err(terr0), .err_clr(1'b0)
   );

   // uart_tx model: latches on load, sends start/8 data LSB-first/even parity/stop,
   // one bit per clock, busy drops while the stop bit is on the line.
   logic        u_loaded, u_busy, u_dead, busy_force, line;
   logic [7:0]  u_byte;
   logic [10:0] u_frame;
   int          u_bit;
   logic        bitq[$];

   assign tx_busy = u_busy | busy_force;

   always @(posedge clk) begin
      if (rst) begin
         u_loaded <= 1'b0; u_busy <= 1'b0; u_bit <= 0; line <= 1'b1;
      end else begin
         if (load_data) begin u_loaded <= 1'b1; u_byte <= datain_tx; end
         if (!u_busy && send_data && u_loaded && !u_dead) begin
            u_frame  <= {1'b1, ^u_byte, u_byte, 1'b0};
            u_busy   <= 1'b1; u_bit <= 0; u_loaded <= 1'b0; line <= 1'b0;
            bitq.push_back(1'b0);
         end else if (u_busy) begin
            u_bit <= u_bit + 1;
            line  <= u_frame[u_bit+1];
            bitq.push_back(u_frame[u_bit+1]);
            if (u_bit + 1 == 10) u_busy <= 1'b0;
         end
      end
   end

   always @(posedge clk) if (!rst && load0) nload0++;

   function automatic int rr_pick(input int last, input logic [3:0] m);
      for (int o = 1; o <= 4; o++) if (m[(last + o) % 4]) return (last + o) % 4;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ack();
      int n = 0;
      do begin tick(); n++; end while (ack == 4'b0 && n < 64);
      vectors++;
      if (ack == 4'b0) begin miscompares++; $display("FAIL ack_timeout: ack=%b required nonzero", ack); end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sched_busy || u_busy) && n < 100) begin tick(); n++; end
      vectors++;
      if (sched_busy || u_busy) begin miscompares++; $display("FAIL idle_timeout: sched_busy=%b required 0", sched_busy); end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if ({ack, load_data, send_data, datain_tx, grant_id, sched_busy, timeout_err} !== 17'b0) begin
         miscompares++;
         $display("FAIL %s: ack=%b load=%b send=%b data=%h gid=%0d busy=%b terr=%b required all 0",
                  tag, ack, load_data, send_data, datain_tx, grant_id, sched_busy, timeout_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; err_clr = 1'b1; req_data = $urandom;
      tick(); tick();
      check_reset_outputs("reset_state");
      vectors++;
      if (ack0 !== 4'b0 || sb0 !== 1'b0) begin miscompares++; $display("FAIL reset_dut0: ack=%b busy=%b required 0", ack0, sb0); end
      req = 4'b0; err_clr = 1'b0; rst = 1'b0; m_last = 3;
   endtask

   task automatic test_single();
      int n;
      int exp_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      bitq.delete();
      req_data = $urandom; req_data[7:0] = 8'hA5; req = 4'b0001;
      tick();
      vectors++;
      if (ack !== 4'b0001 || load_data !== 1'b1 || grant_id !== 2'd0 || datain_tx !== 8'hA5 || sched_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant: ack=%b load=%b gid=%0d data=%h busy=%b required 0001 1 0 a5 1",
                  ack, load_data, grant_id, datain_tx, sched_busy);
      end
      m_last = 0; req = 4'b0;
      tick();
      vectors++;
      if (ack !== 4'b0 || load_data !== 1'b0 || send_data !== 1'b1) begin
         miscompares++; $display("FAIL single_k1: ack=%b load=%b send=%b required 0000 0 1", ack, load_data, send_data);
      end
      n = 1;
      while (send_data && n < 40) begin tick(); n++; end
      vectors++;
      if (n !== 13) begin miscompares++; $display("FAIL single_gap_edge: got k+%0d required k+13", n); end
      tick();
      vectors++;
      if (sched_busy !== 1'b1) begin miscompares++; $display("FAIL single_gap_busy: sched_busy=%b required 1", sched_busy); end
      tick();
      vectors++;
      if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL single_gap_end: sched_busy=%b required 0", sched_busy); end
      vectors++;
      if (bitq.size() !== 11) begin
         miscompares++; $display("FAIL single_frame_len: got %0d bits required 11", bitq.size());
      end else begin
         for (int i = 0; i < 11; i++) begin
            vectors++;
            if (bitq[i] !== exp_bits[i][0]) begin
               miscompares++; $display("FAIL single_frame_bit%0d: got %b required %0d", i, bitq[i], exp_bits[i]);
            end
         end
      end
      wait_idle();
   endtask

   task automatic test_round_robin();
      logic [7:0] b[4];
      int exp, acks, n;
      rst = 1'b1; tick(); rst = 1'b0; m_last = 3;
      for (int i = 0; i < 4; i++) b[i] = 8'(($urandom & 32'h3F) | (i << 6));
      req_data = {b[3], b[2], b[1], b[0]};
      req = 4'b1111;
      // Five frames with all requests held, then randomised masks.
      for (int f = 0; f < 11; f++) begin
         if (f >= 5) begin
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            req_data = {b[3], b[2], b[1], b[0]};
            req = 4'($urandom_range(1, 15));
         end
         wait_ack();
         exp = rr_pick(m_last, req);
         vectors++;
         if (int'(grant_id) !== exp || ack !== 4'(1 << exp) || datain_tx !== b[exp]) begin
            miscompares++;
            $display("FAIL rr_frame%0d: gid=%0d ack=%b data=%h required %0d %b %h",
                     f, grant_id, ack, datain_tx, exp, 4'(1 << exp), b[exp]);
         end
         m_last = exp;
         if (f >= 5) req = 4'b0;
         acks = 1; n = 0;
         do begin tick(); n++; if (ack != 4'b0) acks++; end while (sched_busy && n < 100);
         vectors++;
         if (acks !== 1) begin miscompares++; $display("FAIL rr_ack_count%0d: got %0d required 1", f, acks); end
      end
      req = 4'b0;
      wait_idle();
   endtask

   task automatic test_busy_block();
      busy_force = 1'b1; req = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (ack !== 4'b0) begin miscompares++; $display("FAIL busy_hold%0d: ack=%b required 0000", i, ack); end
      end
      busy_force = 1'b0;
      tick();
      vectors++;
      if (ack !== 4'b0100 || grant_id !== 2'd2) begin
         miscompares++; $display("FAIL busy_release: ack=%b gid=%0d required 0100 2", ack, grant_id);
      end
      m_last = 2; req = 4'b0;
      wait_idle();
      busy_force = 1'b1; req = 4'b1000;
      tick(); tick(); tick();
      req = 4'b0; busy_force = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (ack !== 4'b0 || sched_busy !== 1'b0) begin
            miscompares++; $display("FAIL withdraw%0d: ack=%b busy=%b required 0000 0", i, ack, sched_busy);
         end
      end
   endtask

   task automatic test_timeout();
      int exp;
      u_dead = 1'b1; req = 4'b0010;
      wait_ack();
      exp = rr_pick(m_last, req);
      vectors++;
      if (int'(grant_id) !== exp) begin miscompares++; $display("FAIL tmo_grant: gid=%0d required %0d", grant_id, exp); end
      m_last = exp; req = 4'b0;
      for (int i = 1; i <= 16; i++) tick();
      vectors++;
      if (timeout_err !== 1'b0 || send_data !== 1'b1) begin
         miscompares++; $display("FAIL tmo_early: terr=%b send=%b required 0 1", timeout_err, send_data);
      end
      tick();
      vectors++;
      if (timeout_err !== 1'b1 || send_data !== 1'b0 || sched_busy !== 1'b1) begin
         miscompares++; $display("FAIL tmo_fire: terr=%b send=%b busy=%b required 1 0 1", timeout_err, send_data, sched_busy);
      end
      req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (ack !== 4'b0 || load_data !== 1'b0 || send_data !== 1'b0 || timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL halt%0d: ack=%b load=%b send=%b terr=%b required 0 0 0 1",
                                    i, ack, load_data, send_data, timeout_err);
         end
      end
      err_clr = 1'b1;
      tick();
      vectors++;
      if (timeout_err !== 1'b0 || sched_busy !== 1'b0 || ack !== 4'b0) begin
         miscompares++; $display("FAIL err_clr: terr=%b busy=%b ack=%b required 0 0 0000", timeout_err, sched_busy, ack);
      end
      err_clr = 1'b0; u_dead = 1'b0;
      tick();
      exp = rr_pick(m_last, req);
      vectors++;
      if (ack !== 4'(1 << exp)) begin miscompares++; $display("FAIL post_halt_grant: ack=%b required %b", ack, 4'(1 << exp)); end
      m_last = exp; req = 4'b0;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      req = 4'b0100;
      wait_ack();
      req = 4'b0;
      while (!(u_busy && u_bit == 4) && n < 40) begin tick(); n++; end
      vectors++;
      if (!(u_busy && u_bit == 4)) begin miscompares++; $display("FAIL mid_frame_reach: bit=%0d required 4", u_bit); end
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_frame_reset");
      rst = 1'b0; m_last = 3; req = 4'b1111;
      tick();
      vectors++;
      if (ack !== 4'b0001 || grant_id !== 2'd0) begin
         miscompares++; $display("FAIL reset_first_grant: ack=%b gid=%0d required 0001 0", ack, grant_id);
      end
      m_last = 0; req = 4'b0;
      wait_idle();
   endtask

   task automatic test_gap0();
      int n;
      nload0 = 0; req_data0 = $urandom; req0 = 4'b0010;
      for (int f = 0; f < 3; f++) begin
         n = 0;
         do begin tick(); n++; end while (ack0 == 4'b0 && n < 64);
         vectors++;
         if (ack0 !== 4'b0010 || gid0 !== 2'd1 || data0 !== req_data0[15:8]) begin
            miscompares++; $display("FAIL gap0_grant%0d: ack=%b gid=%0d data=%h required 0010 1 %h",
                                    f, ack0, gid0, data0, req_data0[15:8]);
         end
         tick(); tick();
         busy0 = 1'b1;
         repeat (11) tick();
         busy0 = 1'b0;
         tick();
         vectors++;
         if (send0 !== 1'b0 || sb0 !== 1'b0) begin
            miscompares++; $display("FAIL gap0_skip%0d: send=%b busy=%b required 0 0", f, send0, sb0);
         end
         if (f == 2) req0 = 4'b0;
      end
      tick(); tick(); tick();
      vectors++;
      if (nload0 !== 3 || ack0 !== 4'b0) begin
         miscompares++; $display("FAIL gap0_loads: loads=%0d ack=%b required 3 0000", nload0, ack0);
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; req_data = '0; err_clr = 1'b0;
      busy_force = 1'b0; u_dead = 1'b0;
      req0 = '0; req_data0 = '0; busy0 = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_busy_block();
      test_timeout();
      test_reset_mid();
      test_gap0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
